// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner : per-channel synchroniser + counter debouncer with
//                      clean level and one-cycle press/release strobes
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module button_conditioner #(
   parameter int NUM_INPUTS      = 4,
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter bit ACTIVE_HIGH     = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_INPUTS-1:0] raw_in,
   output logic [NUM_INPUTS-1:0] level,
   output logic [NUM_INPUTS-1:0] press,
   // "release" is a reserved word, hence the suffixed name
   output logic [NUM_INPUTS-1:0] release_o
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [0:0] ST_STABLE  = 1'b0;
   localparam logic [0:0] ST_CONFIRM = 1'b1;

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
      $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
   end

   logic [NUM_INPUTS-1:0] w_s;
   logic [NUM_INPUTS-1:0] sync1_q;
   logic [NUM_INPUTS-1:0] sync2_q;

   assign w_s = ACTIVE_HIGH ? raw_in : ~raw_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= w_s;
         sync2_q <= sync1_q;
      end
   end

   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_ch
      logic [0:0]       state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             level_q, level_d;
      logic             press_q, press_d;
      logic             rel_q, rel_d;
      logic             w_commit;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
         end
      end

      always_comb begin
         state_d  = state_q;
         cnt_d    = cnt_q;
         w_commit = 1'b0;
         case (state_q)
            ST_STABLE: begin
               cnt_d = '0;
               if (sync2_q[g] != level_q) begin
                  state_d = ST_CONFIRM;
                  cnt_d   = CNT_W'(1);
               end
            end
            ST_CONFIRM: begin
               if (sync2_q[g] == level_q) begin
                  state_d = ST_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  // DEBOUNCE_CYCLES consecutive disagreeing samples seen
                  w_commit = 1'b1;
                  state_d  = ST_STABLE;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end
         endcase
      end

      always_comb begin
         level_d = w_commit ? ~level_q : level_q;
         press_d = w_commit & ~level_q;
         rel_d   = w_commit &  level_q;
      end

      assign level[g]     = level_q;
      assign press[g]     = press_q;
      assign release_o[g] = rel_q;
   end

endmodule

`default_nettype wire
